// File: rtl/instruction_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, halt causes,
// BranchALU modes and the RV32I base opcodes it recognises.
package instruction_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        EXECUTE  = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } SequencerState_t;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        ILLEGAL    = 3'd1,
        ECALL      = 3'd2,
        BAD_FUNCT3 = 3'd3,
        MISALIGNED = 3'd4
    } HaltCause_t;

    typedef enum logic [1:0] {
        INCREMENT = 2'd0,
        JAL       = 2'd1,
        JALR      = 2'd2,
        BRANCH    = 2'd3
    } BranchALUMode_t;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_sequencer_decoder.sv
// Combinational opcode classifier for the latched instruction register.
module instruction_sequencer_decoder
    import instruction_sequencer_pkg::*;
(
    input  logic [6:0]     opcode,
    input  logic [4:0]     rd,
    output BranchALUMode_t branch_alu_mode,
    output logic           is_legal,
    output logic           is_system,
    output logic           is_mem,
    output logic           is_load,
    output logic           writes_rd
);

    logic has_rd_s;

    // Classify the opcode; writes to x0 are squashed here so the FSM never strobes for them.
    always_comb begin
        branch_alu_mode = INCREMENT;
        is_legal        = 1'b1;
        is_system       = 1'b0;
        is_mem          = 1'b0;
        is_load         = 1'b0;
        has_rd_s        = 1'b0;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_OP_IMM, OPCODE_OP: has_rd_s = 1'b1;
            OPCODE_JAL: begin
                branch_alu_mode = JAL;
                has_rd_s        = 1'b1;
            end
            OPCODE_JALR: begin
                branch_alu_mode = JALR;
                has_rd_s        = 1'b1;
            end
            OPCODE_BRANCH:   branch_alu_mode = BRANCH;
            OPCODE_LOAD: begin
                is_mem   = 1'b1;
                is_load  = 1'b1;
                has_rd_s = 1'b1;
            end
            OPCODE_STORE:    is_mem = 1'b1;
            OPCODE_MISC_MEM: is_legal = 1'b1;
            OPCODE_SYSTEM:   is_system = 1'b1;
            default:         is_legal = 1'b0;
        endcase
    end

    assign writes_rd = has_rd_s && (rd != 5'd0);

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/execute control FSM and program-counter owner. Fetches through a
// ready/request handshake, drives the BranchALU mode, stalls on memory ops, halts on faults.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic           clock,
    input  logic           reset,
    output logic           fetchRequest,
    output logic [31:0]    fetchAddress,
    input  logic           fetchReady,
    input  logic [31:0]    fetchInstruction,
    output logic [31:0]    instruction,
    output logic [31:0]    pcOfInstruction,
    output BranchALUMode_t branchALUMode,
    input  logic [31:0]    programCounterInput,
    input  logic           branchALUBadBRANCHFunct3,
    output logic           memStart,
    input  logic           memDone,
    output logic           rdWriteEnable,
    output logic [31:0]    retiredCount,
    output logic           halted,
    output HaltCause_t     haltCause
);

    SequencerState_t state_r;
    SequencerState_t next_state_s;
    HaltCause_t      next_cause_s;
    HaltCause_t      halt_cause_r;
    logic [31:0]     pc_r;
    logic [31:0]     ir_r;
    logic [31:0]     ir_pc_r;
    logic [31:0]     retired_r;
    logic            halted_r;
    logic            commit_s;
    logic            fetch_req_s;
    logic            mem_start_s;
    logic            write_rd_s;

    BranchALUMode_t  dec_mode_s;
    logic            dec_legal_s;
    logic            dec_system_s;
    logic            dec_mem_s;
    logic            dec_load_s;
    logic            dec_writes_rd_s;

    instruction_sequencer_decoder u_decoder (
        .opcode          (ir_r[6:0]),
        .rd              (ir_r[11:7]),
        .branch_alu_mode (dec_mode_s),
        .is_legal        (dec_legal_s),
        .is_system       (dec_system_s),
        .is_mem          (dec_mem_s),
        .is_load         (dec_load_s),
        .writes_rd       (dec_writes_rd_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and commit decision; fault checks are in priority order.
    always_comb begin
        next_state_s = state_r;
        next_cause_s = NONE;
        commit_s     = 1'b0;
        case (state_r)
            FETCH: begin
                if (fetchReady) begin
                    next_state_s = EXECUTE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            EXECUTE: begin
                if (!dec_legal_s) begin
                    next_state_s = HALTED;
                    next_cause_s = ILLEGAL;
                end else if (dec_system_s) begin
                    next_state_s = HALTED;
                    next_cause_s = ECALL;
                end else if (branchALUBadBRANCHFunct3 && (dec_mode_s == BRANCH)) begin
                    next_state_s = HALTED;
                    next_cause_s = BAD_FUNCT3;
                end else if ((dec_mode_s != INCREMENT) && !is_word_aligned(programCounterInput)) begin
                    // a not-taken branch yields PC+4, which is always aligned
                    next_state_s = HALTED;
                    next_cause_s = MISALIGNED;
                end else if (dec_mem_s) begin
                    next_state_s = MEM_WAIT;
                end else begin
                    next_state_s = FETCH;
                    commit_s     = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (memDone) begin
                    next_state_s = FETCH;
                    commit_s     = 1'b1;
                end else begin
                    next_state_s = MEM_WAIT;
                end
            end
            HALTED:  next_state_s = HALTED;
            default: next_state_s = HALTED;
        endcase
    end

    // Strobe and mode decode from the registered state.
    always_comb begin
        fetch_req_s   = 1'b0;
        mem_start_s   = 1'b0;
        write_rd_s    = 1'b0;
        branchALUMode = dec_mode_s;
        case (state_r)
            FETCH:   fetch_req_s = 1'b1;
            EXECUTE: begin
                mem_start_s = (next_state_s == MEM_WAIT);
                write_rd_s  = commit_s && dec_writes_rd_s;
            end
            MEM_WAIT: begin
                branchALUMode = INCREMENT;
                write_rd_s    = memDone && dec_load_s && dec_writes_rd_s;
            end
            HALTED:  fetch_req_s = 1'b0;
            default: fetch_req_s = 1'b0;
        endcase
    end

    // PC, instruction register, retire counter and sticky halt status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r         <= RESET_VECTOR;
            ir_r         <= NOP_INSTRUCTION;
            ir_pc_r      <= RESET_VECTOR;
            retired_r    <= 32'd0;
            halted_r     <= 1'b0;
            halt_cause_r <= NONE;
        end else begin
            if ((state_r == FETCH) && fetchReady) begin
                ir_r    <= fetchInstruction;
                ir_pc_r <= pc_r;
            end
            if (commit_s) begin
                pc_r      <= programCounterInput;
                retired_r <= retired_r + 32'd1;
            end
            if ((next_state_s == HALTED) && (state_r != HALTED)) begin
                halted_r     <= 1'b1;
                halt_cause_r <= next_cause_s;
            end
        end
    end

    assign fetchRequest    = fetch_req_s && reset;
    assign memStart        = mem_start_s && reset;
    assign rdWriteEnable   = write_rd_s && reset;
    assign fetchAddress    = pc_r;
    assign instruction     = ir_r;
    assign pcOfInstruction = ir_pc_r;
    assign retiredCount    = retired_r;
    assign halted          = halted_r;
    assign haltCause       = halt_cause_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed scenarios plus random instruction streams checked
// against an instruction-level model of PC, retire count and per-instruction strobes.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    localparam logic [31:0] RV = 32'h00000100;

    localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LD = 7'b0000011;
    localparam logic [6:0] T_ST = 7'b0100011, T_OPI = 7'b0010011, T_OP = 7'b0110011;
    localparam logic [6:0] T_FENCE = 7'b0001111, T_SYS = 7'b1110011;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           fetchRequest;
    logic [31:0]    fetchAddress;
    logic           fetchReady = 1'b0;
    logic [31:0]    fetchInstruction = 32'd0;
    logic [31:0]    instruction;
    logic [31:0]    pcOfInstruction;
    BranchALUMode_t branchALUMode;
    logic [31:0]    programCounterInput = 32'd0;
    logic           branchALUBadBRANCHFunct3 = 1'b0;
    logic           memStart;
    logic           memDone = 1'b0;
    logic           rdWriteEnable;
    logic [31:0]    retiredCount;
    logic           halted;
    HaltCause_t     haltCause;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    instruction_sequencer #(.RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset),
        .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
        .fetchReady(fetchReady), .fetchInstruction(fetchInstruction),
        .instruction(instruction), .pcOfInstruction(pcOfInstruction),
        .branchALUMode(branchALUMode), .programCounterInput(programCounterInput),
        .branchALUBadBRANCHFunct3(branchALUBadBRANCHFunct3),
        .memStart(memStart), .memDone(memDone), .rdWriteEnable(rdWriteEnable),
        .retiredCount(retiredCount), .halted(halted), .haltCause(haltCause)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic op_legal(input logic [6:0] op);
        return (op == T_LUI) || (op == T_AUIPC) || (op == T_JAL) || (op == T_JALR) || (op == T_BR) ||
               (op == T_LD) || (op == T_ST) || (op == T_OPI) || (op == T_OP) || (op == T_FENCE) ||
               (op == T_SYS);
    endfunction

    function automatic logic op_has_rd(input logic [6:0] op);
        return (op == T_LUI) || (op == T_AUIPC) || (op == T_JAL) || (op == T_JALR) ||
               (op == T_LD) || (op == T_OPI) || (op == T_OP);
    endfunction

    function automatic BranchALUMode_t op_mode(input logic [6:0] op);
        if (op == T_JAL) return JAL;
        else if (op == T_JALR) return JALR;
        else if (op == T_BR) return BRANCH;
        else return INCREMENT;
    endfunction

    function automatic HaltCause_t exp_cause(input logic [6:0] op, input logic [31:0] tgt, input logic bad);
        if (!op_legal(op)) return ILLEGAL;
        if (op == T_SYS) return ECALL;
        if ((op == T_BR) && bad) return BAD_FUNCT3;
        if (((op == T_JAL) || (op == T_JALR) || (op == T_BR)) && (tgt[1:0] != 2'b00)) return MISALIGNED;
        return NONE;
    endfunction

    // Asserts reset for one edge and checks the reset-state outputs; ends with reset released.
    task automatic do_reset();
        reset = 1'b0;
        fetchReady = 1'b0;
        memDone = 1'b0;
        branchALUBadBRANCHFunct3 = 1'b0;
        @(negedge clock);
        check("rst_freq", 32'(fetchRequest), 32'd0);
        check("rst_mstart", 32'(memStart), 32'd0);
        check("rst_rdwe", 32'(rdWriteEnable), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cause", 32'(haltCause), 32'(NONE));
        check("rst_count", retiredCount, 32'd0);
        check("rst_ir", instruction, 32'h00000013);
        check("rst_pc", fetchAddress, RV);
        tick();
        reset = 1'b1;
        m_pc = RV;
        m_count = 32'd0;
    endtask

    // Runs one instruction through fetch/execute(/mem wait) and checks it against the model.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] tgt, input logic bad,
                             input int fdelay, input int mdelay);
        logic [6:0]  op;
        logic        is_mem;
        logic        wr;
        HaltCause_t  cause;
        op     = instr[6:0];
        is_mem = (op == T_LD) || (op == T_ST);
        wr     = op_has_rd(op) && (instr[11:7] != 5'd0);
        cause  = exp_cause(op, tgt, bad);
        fetchReady = 1'b0;
        memDone = 1'b0;
        branchALUBadBRANCHFunct3 = 1'b0;
        programCounterInput = m_pc + 32'd4;
        for (int i = 0; i < fdelay; i++) begin
            @(negedge clock);
            check("fetch_wait_req", 32'(fetchRequest), 32'd1);
            check("fetch_wait_addr", fetchAddress, m_pc);
            tick();
        end
        fetchReady = 1'b1;
        fetchInstruction = instr;
        @(negedge clock);
        check("fetch_req", 32'(fetchRequest), 32'd1);
        check("fetch_addr", fetchAddress, m_pc);
        check("count", retiredCount, m_count);
        check("not_halted", 32'(halted), 32'd0);
        tick();
        fetchReady = 1'b0;
        fetchInstruction = 32'($urandom());
        programCounterInput = tgt;
        branchALUBadBRANCHFunct3 = bad;
        memDone = 1'($urandom_range(0, 1));
        @(negedge clock);
        check("ex_mode", 32'(branchALUMode), 32'(op_mode(op)));
        check("ex_ir", instruction, instr);
        check("ex_irpc", pcOfInstruction, m_pc);
        check("ex_freq", 32'(fetchRequest), 32'd0);
        if (cause != NONE) begin
            check("halt_mstart", 32'(memStart), 32'd0);
            check("halt_rdwe", 32'(rdWriteEnable), 32'd0);
            tick();
            fetchReady = 1'b1;
            memDone = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(negedge clock);
                check("halted", 32'(halted), 32'd1);
                check("halt_cause", 32'(haltCause), 32'(cause));
                check("halt_freq", 32'(fetchRequest), 32'd0);
                check("halt_pc", fetchAddress, m_pc);
                check("halt_count", retiredCount, m_count);
                check("halt_strobes", 32'({memStart, rdWriteEnable}), 32'd0);
                tick();
            end
            do_reset();
        end else if (is_mem) begin
            check("ex_mstart", 32'(memStart), 32'd1);
            check("ex_rdwe_mem", 32'(rdWriteEnable), 32'd0);
            tick();
            memDone = 1'b0;
            branchALUBadBRANCHFunct3 = 1'b0;
            programCounterInput = m_pc + 32'd4;
            for (int i = 0; i < mdelay; i++) begin
                @(negedge clock);
                check("mw_strobes", 32'({memStart, rdWriteEnable}), 32'd0);
                check("mw_mode", 32'(branchALUMode), 32'(INCREMENT));
                tick();
            end
            memDone = 1'b1;
            @(negedge clock);
            check("mw_done_rdwe", 32'(rdWriteEnable), 32'((op == T_LD) && wr));
            check("mw_done_mstart", 32'(memStart), 32'd0);
            tick();
            memDone = 1'b0;
            m_pc = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end else begin
            check("ex_mstart0", 32'(memStart), 32'd0);
            check("ex_rdwe", 32'(rdWriteEnable), 32'(wr));
            tick();
            m_pc = tgt;
            m_count = m_count + 32'd1;
        end
    endtask

    // Load whose MEM_WAIT is cut short by reset: no write, no replayed memStart.
    task automatic abort_load();
        fetchReady = 1'b1;
        fetchInstruction = 32'h00002103;
        programCounterInput = m_pc + 32'd4;
        @(negedge clock);
        check("ab_addr", fetchAddress, m_pc);
        tick();
        fetchReady = 1'b0;
        @(negedge clock);
        check("ab_mstart", 32'(memStart), 32'd1);
        tick();
        @(negedge clock);
        check("ab_mw_mstart", 32'(memStart), 32'd0);
        reset = 1'b0;
        memDone = 1'b1;
        #1;
        check("ab_rst_rdwe", 32'(rdWriteEnable), 32'd0);
        check("ab_rst_freq", 32'(fetchRequest), 32'd0);
        tick();
        reset = 1'b1;
        memDone = 1'b0;
        m_pc = RV;
        m_count = 32'd0;
        @(negedge clock);
        check("ab_post_addr", fetchAddress, RV);
        check("ab_post_freq", 32'(fetchRequest), 32'd1);
        check("ab_post_mstart", 32'(memStart), 32'd0);
        check("ab_post_count", retiredCount, 32'd0);
        tick();
    endtask

    logic [6:0] alu_ops [5] = '{T_LUI, T_AUIPC, T_OPI, T_OP, T_FENCE};

    initial begin
        logic [31:0] r;
        logic [31:0] t;
        logic [31:0] tgt;
        logic [6:0]  op;
        logic        bad;
        int          cls;

        do_reset();
        // addi x1,x0,5 with a 3-cycle fetch stall, then jumps to 0x200 and jal x1,+8
        run_instr(32'h00500093, RV + 32'd4, 1'b0, 3, 0);
        check("addi_pc", m_pc, 32'h00000104);
        run_instr(32'h0000006F, 32'h00000200, 1'b0, 0, 0);
        run_instr(32'h008000EF, 32'h00000208, 1'b0, 1, 0);
        run_instr(32'h00002103, 32'h0000020C, 1'b0, 0, 3);
        run_instr(32'h00002063, 32'h00000300, 1'b1, 0, 0);
        run_instr(32'h00000000, RV + 32'd4, 1'b0, 0, 0);
        run_instr(32'h00000073, RV + 32'd4, 1'b0, 2, 0);
        run_instr(32'h000000EF, 32'h00000402, 1'b0, 0, 0);
        run_instr(32'h00000013, RV + 32'd4, 1'b0, 0, 0);
        abort_load();

        for (int n = 0; n < 150; n++) begin
            r   = $urandom();
            t   = $urandom();
            cls = int'($urandom_range(0, 99));
            tgt = m_pc + 32'd4;
            bad = 1'($urandom_range(0, 1));
            if (cls < 30) begin
                op = alu_ops[$urandom_range(0, 4)];
            end else if (cls < 48) begin
                op  = ($urandom_range(0, 1) == 0) ? T_JAL : T_JALR;
                tgt = {t[31:2], 2'b00};
                if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            end else if (cls < 66) begin
                op  = T_BR;
                bad = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 1) == 0) tgt = {t[31:2], 2'b00};
                if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'b10;
            end else if (cls < 92) begin
                op = ($urandom_range(0, 1) == 0) ? T_LD : T_ST;
            end else if (cls < 95) begin
                op = T_SYS;
            end else begin
                op = 7'd0;
                for (int k = 0; k < 20; k++) begin
                    op = 7'($urandom_range(0, 127));
                    if (!op_legal(op)) break;
                end
                if (op_legal(op)) op = 7'd0;
            end
            run_instr({r[31:7], op}, tgt, bad, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        @(negedge clock);
        check("final_count", retiredCount, m_count);
        check("final_pc", fetchAddress, m_pc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
